// File: rtl/sort_sched_if.sv
// Handshake and read-port bundle for the sort scheduler.
// The master side is the job/read client, the slave side is sort_sched.
interface sort_sched_if #(
    parameter int W = 8
);
    logic         start;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         busy;
    logic         done;
    logic [1:0]   rd_req;
    logic [3:0]   rd_addr0;
    logic [3:0]   rd_addr1;
    logic [1:0]   rd_gnt;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         rd_id;
    logic [7:0]   swap_cnt;

    modport master (
        output start, load_valid, load_data, rd_req, rd_addr0, rd_addr1,
        input  load_ready, busy, done, rd_gnt, rd_valid, rd_data, rd_id, swap_cnt
    );

    modport slave (
        input  start, load_valid, load_data, rd_req, rd_addr0, rd_addr1,
        output load_ready, busy, done, rd_gnt, rd_valid, rd_data, rd_id, swap_cnt
    );
endinterface

// File: rtl/sort_sched.sv
// Load-then-bubble-sort buffer with early-exit passes and a two-requester
// round-robin read port that is only live once the buffer is sorted.
module sort_sched #(
    parameter int SIZE = 15,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    sort_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(SIZE - 1);
    localparam logic [3:0] LAST_J0  = 4'(SIZE - 2);

    state_t       r_state;
    logic [W-1:0] r_mem [SIZE];
    logic [3:0]   r_idx;
    logic [3:0]   r_i;
    logic [3:0]   r_j;
    logic         r_flag;
    logic         r_prio;
    logic [7:0]   r_swapCnt;
    logic         r_loadReady;
    logic         r_busy;
    logic         r_done;
    logic [1:0]   r_gnt;
    logic         r_valid;
    logic         r_id;
    logic [W-1:0] r_data;

    logic [W-1:0] w_lo;
    logic [W-1:0] w_hi;
    logic         w_doSwap;
    logic         w_passEnd;
    logic         w_passSwapped;
    logic         w_startJob;
    logic         w_winner;
    logic [3:0]   w_addr;
    logic [W-1:0] w_rdData;

    assign w_lo          = r_mem[r_j];
    assign w_hi          = r_mem[r_j + 4'd1];
    assign w_doSwap      = w_lo > w_hi;
    assign w_passEnd     = (r_j == (LAST_J0 - r_i));
    assign w_passSwapped = r_flag | w_doSwap;
    assign w_startJob    = bus.start && (r_state == IDLE || r_state == DONE);

    // A lone requester always wins; on contention the priority pointer decides.
    always_comb begin
        w_winner = r_prio;
        if (bus.rd_req == 2'b01) begin
            w_winner = 1'b0;
        end else if (bus.rd_req == 2'b10) begin
            w_winner = 1'b1;
        end
        w_addr   = w_winner ? bus.rd_addr1 : bus.rd_addr0;
        w_rdData = (w_addr < 4'(SIZE)) ? r_mem[w_addr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_flag      <= 1'b0;
            r_prio      <= 1'b0;
            r_swapCnt   <= '0;
            r_loadReady <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gnt       <= '0;
            r_valid     <= 1'b0;
            r_id        <= 1'b0;
            r_data      <= '0;
            for (int k = 0; k < SIZE; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_startJob) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_swapCnt   <= '0;
            r_done      <= 1'b0;
            r_loadReady <= 1'b1;
            r_busy      <= 1'b1;
            r_gnt       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: ;
                LOAD: begin
                    if (bus.load_valid) begin
                        r_mem[r_idx] <= bus.load_data;
                        if (r_idx == LAST_IDX) begin
                            r_state     <= SORT;
                            r_loadReady <= 1'b0;
                            r_i         <= '0;
                            r_j         <= '0;
                            r_flag      <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                SORT: begin
                    if (w_doSwap) begin
                        r_mem[r_j]        <= w_hi;
                        r_mem[r_j + 4'd1] <= w_lo;
                        r_swapCnt         <= r_swapCnt + 8'd1;
                    end
                    // A clean pass means the buffer is already ordered.
                    if (w_passEnd) begin
                        if (!w_passSwapped || r_i == LAST_J0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_i    <= r_i + 4'd1;
                            r_j    <= '0;
                            r_flag <= 1'b0;
                        end
                    end else begin
                        r_j    <= r_j + 4'd1;
                        r_flag <= w_passSwapped;
                    end
                end
                DONE: begin
                    if (|bus.rd_req) begin
                        r_gnt   <= w_winner ? 2'b10 : 2'b01;
                        r_valid <= 1'b1;
                        r_id    <= w_winner;
                        r_data  <= w_rdData;
                        r_prio  <= ~w_winner;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = r_loadReady;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rd_gnt     = r_gnt;
    assign bus.rd_valid   = r_valid;
    assign bus.rd_data    = r_data;
    assign bus.rd_id      = r_id;
    assign bus.swap_cnt   = r_swapCnt;
endmodule
